// File: rtl/branch_history_ctrl.sv
// rtl/branch_history_ctrl.sv - gshare PHT sequencer with speculative/committed GHR
// Keeps an in-order queue of predictions and drives PHT counter updates at commit.
module branch_history_ctrl #(
   parameter int I_WIDTH = 7,
   parameter int DEPTH   = 8
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             fetchBranch,
   input  logic [I_WIDTH:0] fetchPC,
   input  logic [1:0]       state,
   input  logic             commitBranch,
   input  logic             commitTaken,
   input  logic             flush,
   output logic [I_WIDTH:0] index,
   output logic             predictTaken,
   output logic             fetchAccept,
   output logic             full,
   output logic [I_WIDTH:0] previousIndex,
   output logic [1:0]       newState,
   output logic             predictorWrite,
   output logic             validCommit,
   output logic             mispredict
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [I_WIDTH:0] spec_ghr, arch_ghr, arch_ghr_nxt;
   logic [PW-1:0]    head, tail;
   logic [CW-1:0]    count;
   logic             empty, restore;

   logic [I_WIDTH:0] q_index [DEPTH];
   logic [1:0]       q_state [DEPTH];
   logic             q_pred  [DEPTH];

   logic [I_WIDTH:0] head_index;
   logic [1:0]       head_state;
   logic             head_pred;

   assign head_index = q_index[head];
   assign head_state = q_state[head];
   assign head_pred  = q_pred[head];

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   assign index        = fetchPC ^ spec_ghr;
   assign predictTaken = state[1];

   // Strobes are gated by rstN so they drop the moment reset asserts.
   assign validCommit    = rstN & commitBranch & ~empty;
   assign mispredict     = validCommit & (commitTaken != head_pred);
   assign fetchAccept    = rstN & fetchBranch & ~full & ~flush & ~mispredict;
   assign predictorWrite = validCommit;
   assign previousIndex  = head_index;

   always_comb begin
      newState = head_state;
      if (commitTaken) begin
         if (head_state != 2'b11) newState = head_state + 2'b01;
      end else begin
         if (head_state != 2'b00) newState = head_state - 2'b01;
      end
   end

   assign arch_ghr_nxt = validCommit ? {arch_ghr[I_WIDTH-1:0], commitTaken} : arch_ghr;

   // A mispredict restore equals the post-commit arch GHR, so flush and mispredict share it.
   assign restore = mispredict | flush;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         spec_ghr <= '0;
         arch_ghr <= '0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else begin
         arch_ghr <= arch_ghr_nxt;
         if (restore) begin
            spec_ghr <= arch_ghr_nxt;
            head     <= tail;
            count    <= '0;
         end else begin
            if (fetchAccept) begin
               spec_ghr <= {spec_ghr[I_WIDTH-1:0], predictTaken};
               tail     <= tail + PW'(1);
            end
            if (validCommit) head <= head + PW'(1);
            count <= count + CW'(fetchAccept) - CW'(validCommit);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fetchAccept) begin
         q_index[tail] <= index;
         q_state[tail] <= state;
         q_pred[tail]  <= predictTaken;
      end
   end

endmodule
